// File: rtl/uart_rx_framer.sv
// rtl/uart_rx_framer.sv - oversampled UART receive framer with parity, framing and overrun detection
module uart_rx_framer #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 rx_in,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    input  logic                 overrun_clr,
    output logic                 busy
);

    localparam logic [3:0] START_TGT = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] BIT_TGT   = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_nxt;
    logic                 sync1, rx_s, rx_prev;
    logic [3:0]           cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_en_l, par_odd_l, par_err_r;
    logic                 at_tgt, frame_start, shift_en, par_sample, stop_en, load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1 <= rx_in;
            rx_s  <= sync1;
            if (sample_tick)
                rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        at_tgt = (cnt == ((state == START) ? START_TGT : BIT_TGT));
    end

    always_comb begin
        state_nxt = state;
        if (sample_tick) begin
            case (state)
                IDLE:    if (rx_prev && !rx_s) state_nxt = START;
                START:   if (at_tgt) state_nxt = rx_s ? IDLE : DATA;
                DATA:    if (at_tgt && bit_idx == LAST_BIT) state_nxt = par_en_l ? PARITY : STOP;
                PARITY:  if (at_tgt) state_nxt = STOP;
                STOP:    if (at_tgt) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy        = (state != IDLE);
        frame_start = sample_tick && (state == IDLE) && rx_prev && !rx_s;
        shift_en    = sample_tick && (state == DATA) && at_tgt;
        par_sample  = sample_tick && (state == PARITY) && at_tgt;
        stop_en     = sample_tick && (state == STOP) && at_tgt;
        // A word being handed off this cycle frees the holding register for the new one
        load        = stop_en && (!rx_valid || rx_ready);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= 4'd0;
            bit_idx   <= 3'd0;
            shreg     <= '0;
            par_en_l  <= 1'b0;
            par_odd_l <= 1'b0;
            par_err_r <= 1'b0;
        end else begin
            if (frame_start) begin
                cnt       <= 4'd0;
                bit_idx   <= 3'd0;
                par_en_l  <= parity_en;
                par_odd_l <= parity_odd;
                par_err_r <= 1'b0;
            end else if (sample_tick && state != IDLE) begin
                cnt <= at_tgt ? 4'd0 : cnt + 4'd1;
            end
            if (shift_en) begin
                shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (par_sample)
                par_err_r <= rx_s ^ (^shreg) ^ par_odd_l;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load) begin
                rx_data    <= shreg;
                rx_valid   <= 1'b1;
                frame_err  <= ~rx_s;
                parity_err <= par_err_r;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (stop_en && !load)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_framer.sv
// tb/tb_uart_rx_framer.sv - scoreboard bench for uart_rx_framer with directed frames
module tb_uart_rx_framer;

    logic       clk = 1'b0, rst = 1'b0, sample_tick = 1'b0, rx_in = 1'b1;
    logic       parity_en = 1'b0, parity_odd = 1'b0, rx_ready = 1'b1, overrun_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, overrun, busy;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t q[$];
    int   checks = 0, failures = 0;
    int   tick_n = 0;
    logic tick_q = 1'b0, valid_q = 1'b0;

    uart_rx_framer #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .rx_in(rx_in),
        .parity_en(parity_en), .parity_odd(parity_odd), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_err(frame_err),
        .parity_err(parity_err), .overrun(overrun), .overrun_clr(overrun_clr),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            tick_n++;
            sample_tick = (tick_n % 4 == 0);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) tick_q <= sample_tick;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (rx_valid && !valid_q)
                check("valid_rise_on_tick", int'(tick_q), 1);
            if (rx_valid && rx_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word got=%0h exp=none", rx_data);
                end else begin
                    e = q.pop_front();
                    check("rx_data", int'(rx_data), int'(e.d));
                    check("frame_err", int'(frame_err), int'(e.fe));
                    check("parity_err", int'(parity_err), int'(e.pe));
                end
            end
        end
        valid_q <= rx_valid;
    end

    task automatic line_bit(input logic v);
        rx_in = v;
        repeat (64) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic use_par,
                              input logic par_bit, input logic stop);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(d[i]);
        if (use_par) line_bit(par_bit);
        line_bit(stop);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ctl_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_rx_valid", int'(rx_valid), 0);
        check("reset_rx_data", int'(rx_data), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_overrun", int'(overrun), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_parity_err", int'(parity_err), 0);
        set_ctl_edge();
        rst = 1'b1;
        idle(20);

        q.push_back('{8'hA5, 1'b0, 1'b0});
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        idle(64);

        rx_in = 1'b0;
        idle(12);
        check("false_start_busy", int'(busy), 1);
        rx_in = 1'b1;
        idle(48);
        check("false_start_idle", int'(busy), 0);
        check("false_start_no_valid", int'(rx_valid), 0);

        parity_en  = 1'b1;
        parity_odd = 1'b0;
        q.push_back('{8'h3C, 1'b0, 1'b1});
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        idle(64);
        q.push_back('{8'h3C, 1'b0, 1'b0});
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        idle(64);
        parity_odd = 1'b1;
        q.push_back('{8'h3C, 1'b0, 1'b0});
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        idle(64);
        parity_en  = 1'b0;
        parity_odd = 1'b0;

        q.push_back('{8'h00, 1'b1, 1'b0});
        send_frame(8'h00, 1'b0, 1'b0, 1'b0);
        rx_in = 1'b0;
        idle(160);
        check("break_no_retrigger", int'(busy), 0);
        rx_in = 1'b1;
        idle(128);

        set_ctl_edge();
        rx_ready = 1'b0;
        q.push_back('{8'h11, 1'b0, 1'b0});
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        idle(64);
        check("overrun_held_valid", int'(rx_valid), 1);
        check("overrun_held_data", int'(rx_data), 8'h11);
        check("overrun_set", int'(overrun), 1);
        set_ctl_edge();
        overrun_clr = 1'b1;
        set_ctl_edge();
        overrun_clr = 1'b0;
        check("overrun_cleared", int'(overrun), 0);
        rx_ready = 1'b1;
        idle(20);

        set_ctl_edge();
        rx_ready = 1'b0;
        send_frame(8'h33, 1'b0, 1'b0, 1'b1);
        idle(20);
        check("held_before_reset", int'(rx_valid), 1);
        line_bit(1'b0);
        line_bit(1'b1);
        rx_in = 1'b0;
        idle(32);
        check("mid_frame_busy", int'(busy), 1);
        set_ctl_edge();
        rst = 1'b0;
        #20;
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(rx_valid), 0);
        check("abort_data", int'(rx_data), 0);
        rx_in = 1'b1;
        set_ctl_edge();
        rst      = 1'b1;
        rx_ready = 1'b1;
        idle(140);
        q.push_back('{8'h5A, 1'b0, 1'b0});
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        idle(64);

        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 Parameter OVERSAMPLE, default 16, sets ticks per bit; legal values are powers of two from 8 to 16.
REQ-002 Parameter DATA_BITS, default 8, sets data bits per frame; legal values are 5 to 8.
REQ-003 clk  input  1  system clock; all logic is on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 sample_tick  input  1  one-clk pulse at OVERSAMPLE x baud, supplied by the upstream baud generator.
REQ-006 rx_in  input  1  asynchronous serial line; idles high.
REQ-007 parity_en  input  1  when 1, a parity bit follows the data bits.
REQ-008 parity_odd  input  1  1 = odd parity, 0 = even parity.
REQ-009 rx_data  output  DATA_BITS  received byte, LSB first on the line, right-aligned.
REQ-010 rx_valid  output  1  rx_data, frame_err and parity_err are valid.
REQ-011 rx_ready  input  1  consumer accepts the word when rx_valid=1 and rx_ready=1 in the same cycle.
REQ-012 frame_err  output  1  stop bit was sampled as 0 for the held word.
REQ-013 parity_err  output  1  parity mismatch for the held word; always 0 when parity is disabled.
REQ-014 overrun  output  1  sticky flag: a completed frame was dropped.
REQ-015 overrun_clr  input  1  clears overrun for one cycle.
REQ-016 busy  output  1  1 in every state except IDLE.

Function
REQ-017 rx_in SHALL pass through a 2-FF synchronizer whose flops reset to 1; the output is rx_s.
REQ-018 A tick-sampled register rx_prev SHALL update only on sample_tick and SHALL reset to 1.
REQ-019 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-020 The FSM and the 4-bit tick counter cnt SHALL change only on cycles where sample_tick=1.
REQ-021 Counter rule, applied on a tick in a non-IDLE state:
- if cnt == target: perform the state's action and set cnt to 0;
- otherwise: increment cnt.
REQ-022 Targets: START = OVERSAMPLE/2-1 (7 at default); DATA, PARITY and STOP = OVERSAMPLE-1 (15 at default).
REQ-023 IDLE: on a tick with rx_prev=1 and rx_s=0, the FSM SHALL go to START.
- cnt is set to 0.
- parity_en and parity_odd are latched for the frame.
- The falling-edge requirement stops a held-low line (break) from re-triggering.
REQ-024 START action:
- rx_s=1: false start; return to IDLE with no output.
- rx_s=0: go to DATA with bit index 0.
REQ-025 DATA action:
- shift rx_s into the MSB of a DATA_BITS shift register (LSB-first reception).
- after DATA_BITS bits, go to PARITY if the latched parity_en=1, else go to STOP.
REQ-026 PARITY action: store the error flag = rx_s XOR (XOR of the data bits) XOR latched parity_odd; then go to STOP.
REQ-027 STOP action:
- frame_err_new = ~rx_s.
- deliver the word per REQ-028..030.
- go to IDLE at mid-stop-bit so back-to-back frames are received.
REQ-028 Delivery when the holding register is empty, or is being consumed in that cycle (rx_valid & rx_ready): load rx_data, frame_err and parity_err; rx_valid=1 on the next clk edge.
REQ-029 Delivery when rx_valid=1 and rx_ready=0: drop the new word, keep the held word unchanged, and set overrun=1.
REQ-030 rx_valid SHALL clear on the edge following rx_valid & rx_ready, unless REQ-028 reloads it in that same cycle.
REQ-031 overrun_clr and an overrun event in the same cycle: overrun SHALL remain 1 (set wins).
REQ-032 Latency: rx_valid rises exactly 1 clk after the tick that samples the stop bit.
REQ-033 A pulse on sample_tick while the FSM is idle with rx high SHALL have no effect.

Reset
REQ-034 While rst=0:
- FSM is in IDLE and cnt=0.
- rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0.
- synchronizer flops and rx_prev are 1.
REQ-035 Reset asserted mid-frame SHALL abort the frame immediately with no output, and SHALL discard any held word.
REQ-036 After rst rises, the first frame SHALL be received correctly.

Verification (OVERSAMPLE=16, DATA_BITS=8, sample_tick every 4 clk)
REQ-037 Frame 0xA5, no parity, stop=1 -> rx_data=0xA5, rx_valid=1 one clk after the stop-sample tick, frame_err=0, parity_err=0.
REQ-038 rx_in low for 3 ticks, then high -> no rx_valid, busy returns to 0 after 8 ticks.
REQ-039 0x3C, even parity, parity bit driven 1 -> rx_data=0x3C, parity_err=1; with the correct bit 0 -> parity_err=0.
REQ-040 0x00 with stop bit 0, then line held low for 40 ticks -> one word with frame_err=1; no second word until rx returns high and falls again.
REQ-041 0x11 then 0x22 back-to-back with rx_ready=0 -> rx_data stays 0x11, overrun=1; one overrun_clr pulse -> overrun=0.
REQ-042 rst pulsed low during the DATA state of 0x77, then frame 0x5A -> no 0x77 output; rx_data=0x5A, rx_valid=1.
